ajuste_relogio: RTL and testbench

AJUSTE_RELOGIO -- requirements
Module: ajuste_relogio

---
 rtl/ajuste_relogio.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ajuste_relogio.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ajuste_relogio.sv
`default_nettype none
// ============================================================================
// Module      : ajuste_relogio
// Description : Time-setting controller for a BCD HH:MM clock. Two raw push
//               buttons (mode, inc) are synchronised and debounced. A mode
//               press captures the running time into edit registers. Further
//               presses step through hour and minute editing, and end in a
//               one-cycle load strobe. The controller abandons an idle edit
//               after TIMEOUT cycles. The field being edited blinks.
// Ports       : clk_in            - clock; all state updates on falling edge
//               rst               - asynchronous active-high reset
//               btn_mode, btn_inc - raw buttons, high = pressed, asynchronous
//               cur_h2..cur_m1    - BCD digits of the running time
//               load              - one-cycle strobe to load the clock counters
//               load_h2..load_m1  - BCD edit values (valid while hold=1)
//               hold              - freeze the clock datapath while editing
//               blink_h, blink_m  - blank hour / minute digits
//               state             - RUN=00, SET_H=01, SET_M=10, COMMIT=11
// Revision    : 1.0 - initial release
// ============================================================================
module ajuste_relogio #(
    parameter int DEBOUNCE = 4,
    parameter int BLINK    = 37,
    parameter int TIMEOUT  = 1000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_h2,
    input  logic [3:0] cur_h1,
    input  logic [3:0] cur_m2,
    input  logic [3:0] cur_m1,
    output logic       load,
    output logic [3:0] load_h2,
    output logic [3:0] load_h1,
    output logic [3:0] load_m2,
    output logic [3:0] load_m1,
    output logic       hold,
    output logic       blink_h,
    output logic       blink_m,
    output logic [1:0] state
);

    localparam int DB_W    = $clog2(DEBOUNCE + 1);
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);
    localparam int BLINK_W = $clog2(BLINK + 1);

    localparam logic [DB_W-1:0]    c_db_full    = DB_W'(DEBOUNCE);
    localparam logic [IDLE_W-1:0]  c_idle_last  = IDLE_W'(TIMEOUT - 1);
    localparam logic [BLINK_W-1:0] c_blink_last = BLINK_W'(BLINK - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SET_H  = 2'b01,
        ST_SET_M  = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = mode, bit 1 = inc
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_press;

    assign w_raw = {btn_inc, btn_mode};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic            r_sync1;
        logic            r_sync2;
        logic            r_level;
        logic            r_level_q;
        logic [DB_W-1:0] r_cnt;

        // The accepted level flips on the cycle after DEBOUNCE consecutive
        // mismatches have been counted. With the two synchroniser stages and
        // the edge detector, the press reaches the FSM 2+DEBOUNCE cycles
        // after the raw input is first sampled high.
        always_ff @(negedge clk_in or posedge rst) begin
            if (rst) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_q <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1   <= w_raw[gi];
                r_sync2   <= r_sync1;
                r_level_q <= r_level;
                if (r_sync2 != r_level) begin
                    if (r_cnt == c_db_full) begin
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        // Rising edge only: releases and held buttons give no extra pulse.
        assign w_press[gi] = r_level & ~r_level_q;
    end

    logic w_mode_p;
    logic w_inc_p;

    assign w_mode_p = w_press[0];
    assign w_inc_p  = w_press[1];

    // ------------------------------------------------------------------
    // Edit registers, idle counter, FSM
    // ------------------------------------------------------------------
    logic [3:0]        r_h2, r_h1, r_m2, r_m1;
    logic [3:0]        w_h2, w_h1, w_m2, w_m1;
    logic [IDLE_W-1:0] r_idle;
    logic [IDLE_W-1:0] w_idle_next;
    logic              w_cap_h_ok;
    logic              w_cap_m_ok;

    // Out-of-range captured fields are zeroed one field at a time.
    assign w_cap_h_ok = ((cur_h2 < 4'd2) && (cur_h1 <= 4'd9)) ||
                        ((cur_h2 == 4'd2) && (cur_h1 <= 4'd3));
    assign w_cap_m_ok = (cur_m2 <= 4'd5) && (cur_m1 <= 4'd9);

    always_comb begin
        w_state_next = r_state;
        w_h2         = r_h2;
        w_h1         = r_h1;
        w_m2         = r_m2;
        w_m1         = r_m1;
        w_idle_next  = r_idle;

        unique case (r_state)
            ST_RUN: begin
                w_idle_next = '0;
                if (w_mode_p) begin
                    w_state_next = ST_SET_H;
                    w_h2 = w_cap_h_ok ? cur_h2 : 4'd0;
                    w_h1 = w_cap_h_ok ? cur_h1 : 4'd0;
                    w_m2 = w_cap_m_ok ? cur_m2 : 4'd0;
                    w_m1 = w_cap_m_ok ? cur_m1 : 4'd0;
                end
            end
            ST_SET_H: begin
                // mode is tested first so a coincident inc is discarded
                if (w_mode_p) begin
                    w_state_next = ST_SET_M;
                    w_idle_next  = '0;
                end else if (w_inc_p) begin
                    w_idle_next = '0;
                    if ((r_h2 == 4'd2) && (r_h1 == 4'd3)) begin
                        w_h2 = 4'd0;
                        w_h1 = 4'd0;
                    end else if (r_h1 == 4'd9) begin
                        w_h1 = 4'd0;
                        w_h2 = r_h2 + 4'd1;
                    end else begin
                        w_h1 = r_h1 + 4'd1;
                    end
                end else if (r_idle == c_idle_last) begin
                    w_state_next = ST_RUN;
                    w_idle_next  = '0;
                end else begin
                    w_idle_next = r_idle + 1'b1;
                end
            end
            ST_SET_M: begin
                if (w_mode_p) begin
                    w_state_next = ST_COMMIT;
                    w_idle_next  = '0;
                end else if (w_inc_p) begin
                    w_idle_next = '0;
                    if (r_m1 == 4'd9) begin
                        w_m1 = 4'd0;
                        w_m2 = (r_m2 == 4'd5) ? 4'd0 : (r_m2 + 4'd1);
                    end else begin
                        w_m1 = r_m1 + 4'd1;
                    end
                end else if (r_idle == c_idle_last) begin
                    w_state_next = ST_RUN;
                    w_idle_next  = '0;
                end else begin
                    w_idle_next = r_idle + 1'b1;
                end
            end
            ST_COMMIT: begin
                w_state_next = ST_RUN;
                w_idle_next  = '0;
            end
            default: begin
                w_state_next = ST_RUN;
                w_idle_next  = '0;
            end
        endcase
    end

    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_h2    <= 4'd0;
            r_h1    <= 4'd0;
            r_m2    <= 4'd0;
            r_m1    <= 4'd0;
            r_idle  <= '0;
        end else begin
            r_state <= w_state_next;
            r_h2    <= w_h2;
            r_h1    <= w_h1;
            r_m2    <= w_m2;
            r_m1    <= w_m1;
            r_idle  <= w_idle_next;
        end
    end

    // ------------------------------------------------------------------
    // Blink phase: restarts low on entering an edit state, low otherwise
    // ------------------------------------------------------------------
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic               w_edit_next;
    logic               w_enter_edit;

    assign w_edit_next  = (w_state_next == ST_SET_H) || (w_state_next == ST_SET_M);
    assign w_enter_edit = w_edit_next && (w_state_next != r_state);

    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (!w_edit_next || w_enter_edit) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign state   = r_state;
    assign load    = (r_state == ST_COMMIT);
    assign hold    = (r_state != ST_RUN);
    assign blink_h = (r_state == ST_SET_H) & r_phase;
    assign blink_m = (r_state == ST_SET_M) & r_phase;
    assign load_h2 = r_h2;
    assign load_h1 = r_h1;
    assign load_m2 = r_m2;
    assign load_m1 = r_m1;

endmodule
`default_nettype wire

// File: tb/tb_ajuste_relogio.sv
`default_nettype none
// ============================================================================
// Module      : tb_ajuste_relogio
// Description : Directed self-checking bench for ajuste_relogio. Inputs are
//               driven and outputs sampled on the rising edge, away from the
//               active falling edge of clk_in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ajuste_relogio;

    localparam int D  = 4;
    localparam int BL = 37;
    localparam int TO = 1000;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_h2, cur_h1, cur_m2, cur_m1;
    logic       load;
    logic [3:0] load_h2, load_h1, load_m2, load_m1;
    logic       hold;
    logic       blink_h;
    logic       blink_m;
    logic [1:0] state;

    logic [15:0] disp;
    assign disp = {load_h2, load_h1, load_m2, load_m1};

    int   tests = 0;
    int   fails = 0;
    logic load_seen;

    ajuste_relogio #(
        .DEBOUNCE (D),
        .BLINK    (BL),
        .TIMEOUT  (TO)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .cur_h2   (cur_h2),
        .cur_h1   (cur_h1),
        .cur_m2   (cur_m2),
        .cur_m1   (cur_m1),
        .load     (load),
        .load_h2  (load_h2),
        .load_h1  (load_h1),
        .load_m2  (load_m2),
        .load_m1  (load_m1),
        .hold     (hold),
        .blink_h  (blink_h),
        .blink_m  (blink_m),
        .state    (state)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
    endtask

    task automatic set_cur(input logic [15:0] v);
        {cur_h2, cur_h1, cur_m2, cur_m1} = v;
    endtask

    // Hold long enough for one accepted press, then long enough for the
    // release to be accepted before any following press.
    task automatic press_mode();
        btn_mode = 1'b1;
        cyc(8);
        btn_mode = 1'b0;
        cyc(10);
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        cyc(8);
        btn_inc = 1'b0;
        cyc(10);
    endtask

    initial begin
        rst      = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        set_cur(16'h1234);

        // ---------------- reset state ----------------
        cyc(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_blink", 32'({blink_h, blink_m}), 32'd0);
        chk("rst_disp", 32'(disp), 32'h0000);
        rst = 1'b0;
        cyc(3);

        // ---------------- mode press latency and capture ----------------
        btn_mode = 1'b1;
        cyc(7);
        chk("enter_early", 32'(state), 32'd0);
        cyc(1);
        chk("enter_state", 32'(state), 32'd1);
        chk("enter_hold", 32'(hold), 32'd1);
        chk("enter_load", 32'(load), 32'd0);
        chk("capture", 32'(disp), 32'h1234);
        btn_mode = 1'b0;
        cyc(10);

        // ---------------- debounce in SET_H ----------------
        btn_inc = 1'b1;
        cyc(D - 1);
        btn_inc = 1'b0;
        cyc(12);
        chk("glitch", 32'(disp), 32'h1234);
        btn_inc = 1'b1;
        cyc(D + 5);
        btn_inc = 1'b0;
        cyc(12);
        chk("long_press", 32'(disp), 32'h1334);

        // ---------------- hour increments and wrap ----------------
        repeat (9) press_inc();
        chk("hour_22", 32'(disp), 32'h2234);
        press_inc();
        chk("hour_23", 32'(disp), 32'h2334);
        press_inc();
        chk("hour_wrap", 32'(disp), 32'h0034);
        chk("seth_state", 32'(state), 32'd1);

        // ---------------- minutes ----------------
        press_mode();
        chk("setm_state", 32'(state), 32'd2);
        repeat (25) press_inc();
        chk("min_59", 32'(disp), 32'h0059);
        press_inc();
        chk("min_wrap", 32'(disp), 32'h0000);

        // ---------------- commit ----------------
        btn_mode = 1'b1;
        cyc(7);
        chk("commit_pre", 32'(state), 32'd2);
        chk("commit_pre_ld", 32'(load), 32'd0);
        cyc(1);
        chk("commit_state", 32'(state), 32'd3);
        chk("commit_load", 32'(load), 32'd1);
        chk("commit_hold", 32'(hold), 32'd1);
        chk("commit_disp", 32'(disp), 32'h0000);
        cyc(1);
        chk("post_state", 32'(state), 32'd0);
        chk("post_load", 32'(load), 32'd0);
        chk("post_hold", 32'(hold), 32'd0);
        btn_mode = 1'b0;
        cyc(10);

        // ---------------- inc ignored in RUN ----------------
        press_inc();
        chk("run_inc_state", 32'(state), 32'd0);
        chk("run_inc_disp", 32'(disp), 32'h0000);

        // ---------------- simultaneous presses in SET_M ----------------
        press_mode();
        press_mode();
        chk("both_setm", 32'(state), 32'd2);
        chk("both_cap", 32'(disp), 32'h1234);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        cyc(8);
        chk("both_state", 32'(state), 32'd3);
        chk("both_load", 32'(load), 32'd1);
        chk("both_disp", 32'(disp), 32'h1234);
        cyc(1);
        chk("both_run", 32'(state), 32'd0);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cyc(10);

        // ---------------- blink and timeout in SET_M ----------------
        press_mode();
        btn_mode = 1'b1;
        cyc(8);
        chk("to_setm", 32'(state), 32'd2);
        btn_mode = 1'b0;
        cyc(BL - 1);
        chk("blink_m_lo", 32'(blink_m), 32'd0);
        cyc(1);
        chk("blink_m_hi", 32'(blink_m), 32'd1);
        chk("blink_h_off", 32'(blink_h), 32'd0);
        cyc(BL - 1);
        chk("blink_m_hi2", 32'(blink_m), 32'd1);
        cyc(1);
        chk("blink_m_lo2", 32'(blink_m), 32'd0);
        load_seen = 1'b0;
        repeat (TO + 7 - (2 * BL + 8)) begin
            @(posedge clk_in);
            if (load) load_seen = 1'b1;
        end
        chk("to_before", 32'(state), 32'd2);
        chk("to_no_load", 32'(load_seen), 32'd0);
        cyc(1);
        chk("to_state", 32'(state), 32'd0);
        chk("to_load", 32'(load), 32'd0);
        chk("to_hold", 32'(hold), 32'd0);

        // ---------------- reset mid-edit ----------------
        press_mode();
        press_mode();
        chk("mid_setm", 32'(state), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_hold", 32'(hold), 32'd0);
        chk("mid_rst_load", 32'(load), 32'd0);
        chk("mid_rst_disp", 32'(disp), 32'h0000);
        chk("mid_rst_blink", 32'({blink_h, blink_m}), 32'd0);
        set_cur(16'h2775);
        btn_mode = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(7);
        chk("held_early", 32'(state), 32'd0);
        cyc(1);
        chk("held_enter", 32'(state), 32'd1);
        chk("bad_capture", 32'(disp), 32'h0000);
        cyc(BL);
        chk("blink_h_hi", 32'(blink_h), 32'd1);
        chk("blink_m_off", 32'(blink_m), 32'd0);
        btn_mode = 1'b0;
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
